// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge bus between the IF stage (master) and imem (slave).
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: holds the PC, fetches over a variable-latency req/ack bus and loads IF/ID.
// Define BRANCH_DELAY_SLOT_EN to let the word fetched alongside a redirect execute as a delay slot.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       wpc,
    input  logic [1:0]                 pcsource,
    input  logic [31:0]                bpc,
    input  logic [31:0]                jpc,
    input  logic [31:0]                ra,
    instruction_fetch_if.master        imem,
    output logic [31:0]                pc,
    output logic [31:0]                pc4,
    output logic [31:0]                inst,
    output logic                       if_valid
);

    typedef enum logic {
        S_WAIT = 1'b0,
        S_FULL = 1'b1
    } state_t;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit SQUASH_EN = 1'b0;
`else
    localparam bit SQUASH_EN = 1'b1;
`endif

    state_t      r_state, w_stateNext;
    logic [31:0] r_pc, w_pcNext;
    logic [31:0] r_pc4, w_pc4Next;
    logic [31:0] r_inst, w_instNext;
    logic        r_ifValid, w_ifValidNext;
    logic [31:0] r_buf, w_bufNext;
    logic        r_redirVld, w_redirVldNext;
    logic [31:0] r_redirPc, w_redirPcNext;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_target;
    logic [31:0] w_word;
    logic        w_wordAvail;
    logic        w_deliver;
    logic        w_squash;

    always_comb begin
        w_pcPlus4   = r_pc + 32'd4;
        w_wordAvail = ((r_state == S_WAIT) && imem.imem_ack) || (r_state == S_FULL);
        w_word      = (r_state == S_FULL) ? r_buf : imem.imem_rdata;
        w_deliver   = w_wordAvail && wpc;
        w_squash    = SQUASH_EN && (r_redirVld || (pcsource != 2'b00));

        unique case (pcsource)
            2'b00:   w_target = w_pcPlus4;
            2'b01:   w_target = bpc;
            2'b10:   w_target = ra & 32'hFFFF_FFFC;
            default: w_target = jpc;
        endcase

        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_pc4Next      = r_pc4;
        w_instNext     = r_inst;
        w_ifValidNext  = r_ifValid;
        w_bufNext      = r_buf;
        w_redirVldNext = r_redirVld;
        w_redirPcNext  = r_redirPc;

        if (w_deliver) begin
            // A pending redirect outranks whatever decode is asking for this cycle
            w_pcNext       = r_redirVld ? r_redirPc : w_target;
            w_pc4Next      = w_pcPlus4;
            w_instNext     = w_squash ? NOP_INST : w_word;
            w_ifValidNext  = !w_squash;
            w_stateNext    = S_WAIT;
            w_redirVldNext = 1'b0;
        end else if (w_wordAvail) begin
            if (r_state == S_WAIT) begin
                w_bufNext   = imem.imem_rdata;
                w_stateNext = S_FULL;
            end
        end else if (wpc) begin
            w_instNext    = NOP_INST;
            w_ifValidNext = 1'b0;
            if ((pcsource != 2'b00) && !r_redirVld) begin
                w_redirVldNext = 1'b1;
                w_redirPcNext  = w_target;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= S_WAIT;
            r_pc       <= RESET_PC;
            r_pc4      <= 32'h0000_0000;
            r_inst     <= NOP_INST;
            r_ifValid  <= 1'b0;
            r_buf      <= 32'h0000_0000;
            r_redirVld <= 1'b0;
            r_redirPc  <= 32'h0000_0000;
        end else begin
            r_state    <= w_stateNext;
            r_pc       <= w_pcNext;
            r_pc4      <= w_pc4Next;
            r_inst     <= w_instNext;
            r_ifValid  <= w_ifValidNext;
            r_buf      <= w_bufNext;
            r_redirVld <= w_redirVldNext;
            r_redirPc  <= w_redirPcNext;
        end
    end

    assign imem.imem_req  = (r_state == S_WAIT) && clrn;
    assign imem.imem_addr = r_pc;
    assign pc             = r_pc;
    assign pc4            = r_pc4;
    assign inst           = r_inst;
    assign if_valid       = r_ifValid;

endmodule
